// File: rtl/packer_scheduler.sv
// Round-robin owner arbiter in front of an 8-bit bit-packer, byte-aligning packets with zero padding.
// Optional idle-owner release is enabled by defining PACKER_SCHED_TIMEOUT_EN.
module packer_scheduler #(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [N_REQ-1:0]     req_last,
    input  logic [8*N_REQ-1:0]   req_data_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]     req_ready,
    output logic [7:0]           pk_data_valid,
    output logic [7:0]           pk_data,
    output logic [ID_W-1:0]      pk_id,
    output logic                 pk_last,
    output logic                 busy
);

    typedef enum logic [1:0] {IDLE, OWN, PAD} state_t;

    state_t          state, state_next;
    logic [ID_W-1:0] owner, owner_next;
    logic [ID_W-1:0] rr_ptr, rr_ptr_next;
    logic [2:0]      fill, fill_next;
    logic [ID_W-1:0] grant, sel;
    logic            grant_hit;
    logic [7:0]      sel_dv, sel_data;
    logic            sel_last;
    logic [3:0]      fill_sum;
    logic            accept, pad_beat, end_aligned, timeout_hit;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = '0;
        for (int b = 0; b < 8; b++) c = c + {3'b000, v[b]};
        return c;
    endfunction

    // Walk from the highest offset down so the nearest requester after rr_ptr wins.
    always_comb begin
        grant     = '0;
        grant_hit = 1'b0;
        for (int i = N_REQ; i >= 1; i--) begin
            if (req_valid[(int'(rr_ptr) + i) % N_REQ]) begin
                grant     = ID_W'((int'(rr_ptr) + i) % N_REQ);
                grant_hit = 1'b1;
            end
        end
    end

    assign sel = (state == IDLE) ? grant : owner;

    always_comb begin
        sel_dv   = '0;
        sel_data = '0;
        sel_last = 1'b0;
        for (int r = 0; r < N_REQ; r++) begin
            if (ID_W'(r) == sel) begin
                sel_dv   = req_data_valid[8*r +: 8];
                sel_data = req_data[8*r +: 8];
                sel_last = req_last[r];
            end
        end
    end

    assign fill_sum = {1'b0, fill} + popcount8(sel_dv);

`ifdef PACKER_SCHED_TIMEOUT_EN
    logic [7:0] idle_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            idle_cnt <= '0;
        else if (state != OWN || accept)
            idle_cnt <= '0;
        else if (!req_valid[owner])
            idle_cnt <= idle_cnt + 8'd1;
    end

    assign timeout_hit = (state == OWN) && (idle_cnt >= 8'(TIMEOUT));
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign timeout_hit    = 1'b0;
`endif

    always_comb begin
        state_next  = state;
        owner_next  = owner;
        rr_ptr_next = rr_ptr;
        fill_next   = fill;
        req_ready   = '0;
        accept      = 1'b0;
        pad_beat    = 1'b0;
        end_aligned = 1'b0;
        case (state)
            IDLE: begin
                if (grant_hit) begin
                    req_ready[grant] = 1'b1;
                    accept           = 1'b1;
                    owner_next       = grant;
                    state_next       = OWN;
                end
            end
            OWN: begin
                if (timeout_hit) begin
                    if (fill != 3'd0) begin
                        state_next = PAD;
                    end else begin
                        state_next  = IDLE;
                        rr_ptr_next = owner;
                    end
                end else begin
                    req_ready[owner] = 1'b1;
                    accept           = req_valid[owner];
                end
            end
            PAD: begin
                pad_beat    = 1'b1;
                fill_next   = 3'd0;
                rr_ptr_next = owner;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // A packet that closes mid-byte detours through PAD before the next grant.
        if (accept) begin
            fill_next = fill_sum[2:0];
            if (sel_last) begin
                if (fill_sum[2:0] == 3'd0) begin
                    end_aligned = 1'b1;
                    rr_ptr_next = sel;
                    state_next  = IDLE;
                end else begin
                    state_next = PAD;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            owner  <= '0;
            rr_ptr <= ID_W'(N_REQ - 1);
            fill   <= '0;
        end else begin
            state  <= state_next;
            owner  <= owner_next;
            rr_ptr <= rr_ptr_next;
            fill   <= fill_next;
        end
    end

    // Padding fills the remaining (8-fill) low bit positions of the open byte.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pk_data_valid <= '0;
            pk_data       <= '0;
            pk_id         <= '0;
            pk_last       <= 1'b0;
            busy          <= 1'b0;
        end else begin
            pk_data_valid <= accept ? sel_dv : (pad_beat ? (8'hFF >> fill) : 8'h00);
            pk_data       <= accept ? (sel_data & sel_dv) : 8'h00;
            pk_id         <= accept ? sel : (pad_beat ? owner : pk_id);
            pk_last       <= end_aligned | pad_beat;
            busy          <= (state_next != IDLE);
        end
    end

endmodule
